alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the processor's combinational ALU.
- Same op set (clr, pass, add, sub, mul, inc) plus dec. Adds status flags and a start/done handshake.
- Default multiply is an iterative shift-add, to cut the combinational multiplier out of the core's critical path.
- Sits between the accumulator (a) and the data bus (b). The core's control unit issues operations and waits on done.

Parameters:
- WIDTH, 12: datapath width of a, b and dataOut.
- FAST_MUL, 0: 0 = iterative multiply, WIDTH+1 cycle latency; 1 = single-cycle multiply, same latency as other ops.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstN  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on a rising edge when busy=0.
- selectOp  input  3  0 clr, 1 pass, 2 add, 3 sub, 4 mul, 5 inc, 6 dec, 7 illegal.
- a  input  WIDTH  operand from accumulator.
- b  input  WIDTH  operand from data bus.
- dataOut  output  WIDTH  registered result; holds until the next completion.
- done  output  1  one-cycle pulse; operation complete.
- busy  output  1  high while an iterative multiply is in progress.
- zero  output  1  registered; high when the result written at completion is 0.
- carry  output  1  registered carry/borrow/overflow of the last completed op.
- err  output  1  one-cycle pulse, coincident with done, for illegal op 7.

Behaviour:
- Reset (rstN low, asynchronous, at any time including mid-multiply):
  - dataOut=0, done=0, busy=0, err=0, carry=0, zero=1.
  - FSM goes to IDLE; multiplier state is cleared; no done is issued for the aborted op.
- FSM states: IDLE, MUL.
- IDLE, start=1 sampled at end of cycle N:
  - Non-mul op, or mul with FAST_MUL=1: result, flags and done=1 are visible in cycle N+1. FSM stays in IDLE.
  - Mul with FAST_MUL=0: latch a (multiplicand) and b (multiplier) and clear the 2*WIDTH accumulator. Go to MUL.
- MUL: one multiplier bit per cycle, LSB first; WIDTH iterations in cycles N+1..N+WIDTH.
  - busy=1 in exactly those cycles.
  - After the last iteration: write dataOut, zero and carry, pulse done in cycle N+WIDTH+1, return to IDLE.
- start while busy=1: ignored entirely. Operand inputs are not re-sampled during MUL.
- start in the same cycle done is high (FSM in IDLE): accepted. Back-to-back single-cycle ops give done high every cycle.
- done and err are high for exactly one cycle per accepted op. dataOut is otherwise stable.
- Arithmetic: all results are modulo 2^WIDTH.
- carry per op:
  - add: carry-out of a+b.
  - sub: borrow, i.e. a<b unsigned.
  - inc: a is all-ones.
  - dec: a==0.
  - mul: upper WIDTH bits of the full 2*WIDTH product are nonzero.
  - clr, pass: 0.
- dec result: a-1. clr result: 0. pass result: b.
- Op 7: dataOut holds its previous value, carry=0, zero recomputed from the held dataOut, done=1 and err=1 for one cycle.
- zero is always derived from the value written to dataOut at completion.

Test Plan:
- Reset: assert rstN=0 asynchronously, outside any clock edge -> dataOut=0x000, done=0, busy=0, err=0, carry=0, zero=1 immediately.
- add and inc (WIDTH=12):
  - a=0xFFF, b=0x002, start in cycle 0 -> cycle 1: dataOut=0x001, carry=1, zero=0, done=1; cycle 2: done=0, dataOut held.
  - inc a=0xFFF -> dataOut=0x000, carry=1, zero=1.
- sub and dec:
  - a=5, b=5 -> dataOut=0, zero=1, carry=0.
  - a=3, b=5 -> dataOut=0xFFE, carry=1.
  - dec a=0 -> 0xFFF, carry=1.
  - back-to-back starts -> done high on consecutive cycles.
- Iterative mul (FAST_MUL=0):
  - 0x040*0x040 started cycle 0 -> busy=1 cycles 1-12, done=1 only in cycle 13, dataOut=0x000, carry=1, zero=1.
  - 25*3 -> 75 (0x04B), carry=0.
  - start with op=add in cycle 5 -> ignored; no extra done.
- Reset mid-mul: rstN low in cycle 6 of a multiply -> outputs at reset values, no done. Subsequent add 1+1 -> dataOut=2 in the following cycle.
- Illegal op and fast mul:
  - op 7 after result 0x04B -> done=1, err=1, dataOut=0x04B, carry=0.
  - With FAST_MUL=1, 25*3 -> dataOut=0x04B, done in cycle 1, busy never high.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a start/done handshake and status flags.
//
// Ops (selectOp): 0 clr, 1 pass, 2 add, 3 sub, 4 mul, 5 inc, 6 dec, 7 illegal.
// Single-cycle ops complete one cycle after start is sampled. With
// FAST_MUL=0, mul runs as a shift-add over WIDTH cycles (busy high) and
// completes WIDTH+1 cycles after start. With FAST_MUL=1, mul is single-cycle.
//
// Ports:
//   clk       clock, rising edge
//   rstN      asynchronous active-low reset
//   start     operation request, sampled when busy=0
//   selectOp  operation select
//   a, b      operands (accumulator, data bus)
//   dataOut   registered result, held until the next completion
//   done      one-cycle completion pulse
//   busy      high while an iterative multiply is running
//   zero      result written at completion is zero
//   carry     carry/borrow/overflow of the last completed op
//   err       one-cycle pulse with done for the illegal op
module alu_seq #(
    parameter int WIDTH    = 12,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [2:0]       selectOp,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] dataOut,
    output logic             done,
    output logic             busy,
    output logic             zero,
    output logic             carry,
    output logic             err
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [CW-1:0]        r_cnt;

    logic                 w_accept;
    logic                 w_mul_start;
    logic                 w_mul_last;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH:0]       w_sum;
    logic                 w_cmp;
    logic [WIDTH-1:0]     w_res;
    logic                 w_carry;
    logic                 w_err;

    // start is only honoured in IDLE; a request during MUL is dropped.
    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_mul_start = w_accept && (selectOp == 3'd4) && (FAST_MUL == 1'b0);
    assign w_mul_last  = (r_state == S_MUL) && (r_cnt == CNT_LAST);

    // One partial product per cycle; the final iteration's sum is written
    // straight to dataOut so completion lands one cycle after the last bit.
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign w_sum     = {1'b0, a} + {1'b0, b};

    // State register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_mul_start) w_state_nxt = S_MUL;
            S_MUL:   if (w_mul_last)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: busy plus the completion values to be registered
    always_comb begin
        busy    = (r_state == S_MUL);
        w_cmp   = 1'b0;
        w_res   = dataOut;
        w_carry = 1'b0;
        w_err   = 1'b0;
        if (w_mul_last) begin
            w_cmp   = 1'b1;
            w_res   = w_acc_nxt[WIDTH-1:0];
            w_carry = |w_acc_nxt[2*WIDTH-1:WIDTH];
        end else if (w_accept && !w_mul_start) begin
            w_cmp = 1'b1;
            case (selectOp)
                3'd0: w_res = '0;
                3'd1: w_res = b;
                3'd2: begin
                    w_res   = w_sum[WIDTH-1:0];
                    w_carry = w_sum[WIDTH];
                end
                3'd3: begin
                    w_res   = a - b;
                    w_carry = (a < b);
                end
                3'd4: begin
                    w_res   = w_prod[WIDTH-1:0];
                    w_carry = |w_prod[2*WIDTH-1:WIDTH];
                end
                3'd5: begin
                    w_res   = a + WIDTH'(1);
                    w_carry = &a;
                end
                3'd6: begin
                    w_res   = a - WIDTH'(1);
                    w_carry = (a == '0);
                end
                default: begin
                    // Illegal op: hold the previous result, flag the error.
                    w_res = dataOut;
                    w_err = 1'b1;
                end
            endcase
        end
    end

    // Iterative multiplier datapath
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (w_mul_start) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_cnt    <= '0;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    // Result and flag registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            dataOut <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            carry   <= 1'b0;
            zero    <= 1'b1;
        end else begin
            done <= w_cmp;
            err  <= w_cmp && w_err;
            if (w_cmp) begin
                dataOut <= w_res;
                carry   <= w_carry;
                zero    <= (w_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic        start1;
    logic [2:0]  selectOp;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] dataOut,  dataOut1;
    logic        done,     done1;
    logic        busy,     busy1;
    logic        zero,     zero1;
    logic        carry,    carry1;
    logic        err,      err1;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic [11:0] d;
        logic        c;
        logic        z;
        logic        e;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(12), .FAST_MUL(1'b0)) dut (
        .clk(clk), .rstN(rstN), .start(start), .selectOp(selectOp),
        .a(a), .b(b), .dataOut(dataOut), .done(done), .busy(busy),
        .zero(zero), .carry(carry), .err(err)
    );

    alu_seq #(.WIDTH(12), .FAST_MUL(1'b1)) dut_fast (
        .clk(clk), .rstN(rstN), .start(start1), .selectOp(selectOp),
        .a(a), .b(b), .dataOut(dataOut1), .done(done1), .busy(busy1),
        .zero(zero1), .carry(carry1), .err(err1)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        nchk++;
        assert (obs === expv)
        else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(logic [2:0] op, logic [11:0] ed, logic ec);
        exp_t e;
        e.d = ed;
        e.c = ec;
        e.z = (ed == 12'h000);
        e.e = (op == 3'd7);
        sb.push_back(e);
    endtask

    task automatic pop_chk(string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_data"},  32'(dataOut), 32'(e.d));
            chk({tag, "_carry"}, 32'(carry),   32'(e.c));
            chk({tag, "_zero"},  32'(zero),    32'(e.z));
            chk({tag, "_err"},   32'(err),     32'(e.e));
        end
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_data"},  32'(dataOut), 32'h000);
        chk({tag, "_done"},  32'(done),    32'd0);
        chk({tag, "_busy"},  32'(busy),    32'd0);
        chk({tag, "_err"},   32'(err),     32'd0);
        chk({tag, "_carry"}, 32'(carry),   32'd0);
        chk({tag, "_zero"},  32'(zero),    32'd1);
    endtask

    // Called at a falling edge. Drives one op, then watches lat+3 cycles.
    // inj>0 raises start with an add (and new operands) in cycle inj.
    task automatic run_op(string tag, logic [2:0] op, logic [11:0] ia,
                          logic [11:0] ib, logic [11:0] ed, logic ec,
                          int lat, int inj);
        int ndone = 0;
        int dcyc  = 0;
        int nbusy = 0;
        push_exp(op, ed, ec);
        selectOp = op;
        a        = ia;
        b        = ib;
        start    = 1'b1;
        for (int cyc = 1; cyc <= lat + 3; cyc++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    dcyc = cyc;
                    pop_chk(tag);
                end
            end
            if (cyc == 1) start = 1'b0;
            if (inj != 0 && cyc == inj) begin
                start    = 1'b1;
                selectOp = 3'd2;
                a        = 12'h001;
                b        = 12'h001;
            end
            if (inj != 0 && cyc == inj + 1) start = 1'b0;
        end
        chk({tag, "_ndone"},   32'(ndone),   32'd1);
        chk({tag, "_latency"}, 32'(dcyc),    32'(lat));
        chk({tag, "_nbusy"},   32'(nbusy),   32'((lat > 1) ? lat - 1 : 0));
        chk({tag, "_held"},    32'(dataOut), 32'(ed));
    endtask

    initial begin
        int nd;
        int nb;
        rstN     = 1'b1;
        start    = 1'b0;
        start1   = 1'b0;
        selectOp = 3'd0;
        a        = '0;
        b        = '0;
        #2 rstN = 1'b0;
        #1 chk_reset_vals("por");
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;

        run_op("add_ovf", 3'd2, 12'hFFF, 12'h002, 12'h001, 1'b1, 1, 0);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #3 rstN = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        rstN = 1'b1;

        run_op("inc_wrap", 3'd5, 12'hFFF, 12'h000, 12'h000, 1'b1, 1, 0);
        run_op("sub_eq",   3'd3, 12'h005, 12'h005, 12'h000, 1'b0, 1, 0);
        run_op("sub_brw",  3'd3, 12'h003, 12'h005, 12'hFFE, 1'b1, 1, 0);
        run_op("dec_zero", 3'd6, 12'h000, 12'h123, 12'hFFF, 1'b1, 1, 0);
        run_op("pass",     3'd1, 12'h111, 12'hA5C, 12'hA5C, 1'b0, 1, 0);
        run_op("clr",      3'd0, 12'h7FF, 12'h7FF, 12'h000, 1'b0, 1, 0);

        // Back-to-back single-cycle ops
        push_exp(3'd2, 12'h002, 1'b0);
        push_exp(3'd5, 12'h006, 1'b0);
        selectOp = 3'd2; a = 12'h001; b = 12'h001; start = 1'b1;
        @(negedge clk);
        chk("b2b_done1", 32'(done), 32'd1);
        pop_chk("b2b_1");
        selectOp = 3'd5; a = 12'h005;
        @(negedge clk);
        chk("b2b_done2", 32'(done), 32'd1);
        pop_chk("b2b_2");
        start = 1'b0;
        @(negedge clk);
        chk("b2b_done3", 32'(done), 32'd0);

        // Iterative multiply, with a stray add request in cycle 5
        run_op("mul_ovf", 3'd4, 12'h040, 12'h040, 12'h000, 1'b1, 13, 5);
        run_op("mul_small", 3'd4, 12'd25, 12'd3, 12'h04B, 1'b0, 13, 0);
        run_op("illegal", 3'd7, 12'h321, 12'h654, 12'h04B, 1'b0, 1, 0);

        // Reset during a multiply: no done for the aborted op
        selectOp = 3'd4; a = 12'd25; b = 12'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rstN = 1'b0;
        #1 chk_reset_vals("mid_mul_rst");
        @(negedge clk);
        rstN = 1'b1;
        nd = 0;
        nb = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (busy) nb++;
        end
        chk("mid_mul_no_done", 32'(nd), 32'd0);
        chk("mid_mul_no_busy", 32'(nb), 32'd0);
        run_op("add_after_rst", 3'd2, 12'h001, 12'h001, 12'h002, 1'b0, 1, 0);

        // Single-cycle multiply variant
        selectOp = 3'd4; a = 12'd25; b = 12'd3; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("fmul_done",  32'(done1),    32'd1);
        chk("fmul_busy",  32'(busy1),    32'd0);
        chk("fmul_data",  32'(dataOut1), 32'h04B);
        chk("fmul_carry", 32'(carry1),   32'd0);
        chk("fmul_zero",  32'(zero1),    32'd0);
        @(negedge clk);
        chk("fmul_done_off", 32'(done1), 32'd0);
        a = 12'h040; b = 12'h040; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("fmul_ovf_done",  32'(done1),    32'd1);
        chk("fmul_ovf_data",  32'(dataOut1), 32'h000);
        chk("fmul_ovf_carry", 32'(carry1),   32'd1);
        chk("fmul_ovf_zero",  32'(zero1),    32'd1);
        chk("fmul_ovf_busy",  32'(busy1),    32'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
